// File: rtl/spi_transaction_fsm.sv
// SPI-memory transaction sequencer: counts SCLK edge pulses to capture the
// address/RW byte, then loads the shift register for a read or collects a
// data byte for a write. Outputs are a Moore decode of the state register.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   chipSelect          conditioned CS, active-low
//   sclkPosEdge         one-clk pulse per SCLK rising edge
//   sclkNegEdge         one-clk pulse per SCLK falling edge
//   rwBit               shift register bit 0 (1=read, 0=write)
//   addrWriteEnable     latch address byte
//   srParallelLoad      shift register parallel load
//   dmWriteEnable       data memory write strobe
//   misoBufferEnable    MISO tri-state enable
//   busy                high in every state except IDLE
module spi_transaction_fsm #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic chipSelect,
  input  logic sclkPosEdge,
  input  logic sclkNegEdge,
  input  logic rwBit,
  output logic addrWriteEnable,
  output logic srParallelLoad,
  output logic dmWriteEnable,
  output logic misoBufferEnable,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GOT_ADDR,
    S_READ_LOAD,
    S_READ_SEND,
    S_WRITE_GET,
    S_WRITE_STORE,
    S_DONE
  } state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CNTW-1:0] r_count;
  logic [CNTW-1:0] w_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_count <= w_count;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_count = r_count;
    // CS high outranks every pulse and every one-cycle state
    if (r_state != S_IDLE && chipSelect) begin
      w_next  = S_IDLE;
      w_count = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!chipSelect) begin
            w_next  = S_GET_ADDR;
            w_count = '0;
          end
        end
        S_GET_ADDR: begin
          if (sclkPosEdge) begin
            w_count = r_count + CNTW'(1);
            if (r_count == LAST) w_next = S_GOT_ADDR;
          end
        end
        S_GOT_ADDR: begin
          w_count = '0;
          w_next  = rwBit ? S_READ_LOAD : S_WRITE_GET;
        end
        S_READ_LOAD: begin
          w_next = S_READ_SEND;
        end
        S_READ_SEND: begin
          if (sclkNegEdge) begin
            w_count = r_count + CNTW'(1);
            if (r_count == LAST) w_next = S_DONE;
          end
        end
        S_WRITE_GET: begin
          if (sclkPosEdge) begin
            w_count = r_count + CNTW'(1);
            if (r_count == LAST) w_next = S_WRITE_STORE;
          end
        end
        S_WRITE_STORE: begin
          w_next = S_DONE;
        end
        S_DONE: begin
          w_next = S_DONE;
        end
        default: begin
          w_next  = S_IDLE;
          w_count = '0;
        end
      endcase
    end
  end

  assign addrWriteEnable  = (r_state == S_GOT_ADDR);
  assign srParallelLoad   = (r_state == S_READ_LOAD);
  assign dmWriteEnable    = (r_state == S_WRITE_STORE);
  assign misoBufferEnable = (r_state == S_READ_SEND);
  assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Self-checking bench for spi_transaction_fsm: vector table, directed
// corner sequences and a randomized run against a pulse-counting model.
module tb_spi_transaction_fsm;

  logic clk = 1'b0;
  logic reset, cs, pe, ne, rw;
  logic awe, srl, dme, miso, busy;

  always #5 clk = ~clk;

  spi_transaction_fsm #(.WIDTH(8), .CNTW(4)) dut (
    .clk(clk),
    .reset(reset),
    .chipSelect(cs),
    .sclkPosEdge(pe),
    .sclkNegEdge(ne),
    .rwBit(rw),
    .addrWriteEnable(awe),
    .srParallelLoad(srl),
    .dmWriteEnable(dme),
    .misoBufferEnable(miso),
    .busy(busy)
  );

  // expected output vector order: {awe, srl, dme, miso, busy}
  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_BUSY = 5'b00001;
  localparam logic [4:0] O_AWE  = 5'b10001;
  localparam logic [4:0] O_SRL  = 5'b01001;
  localparam logic [4:0] O_DME  = 5'b00101;
  localparam logic [4:0] O_MISO = 5'b00011;

  int checks = 0;
  int failures = 0;

  task automatic step(input logic r_i, input logic c_i, input logic p_i,
                      input logic n_i, input logic w_i,
                      input logic [4:0] exp, input string name);
    logic [4:0] got;
    reset = r_i; cs = c_i; pe = p_i; ne = n_i; rw = w_i;
    @(posedge clk);
    #1;
    got = {awe, srl, dme, miso, busy};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, exp);
    end
  endtask

  typedef struct {
    logic       r, c, p, n, w;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r_i, input logic c_i,
                              input logic p_i, input logic n_i,
                              input logic w_i, input logic [4:0] e);
    vec_t v;
    v.r = r_i; v.c = c_i; v.p = p_i; v.n = n_i; v.w = w_i; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Reference model: a transaction is described by how many relevant
  // pulses have been seen and how many clocks have passed since the
  // address byte completed.
  bit m_act, m_rw, m_stored;
  int m_addr, m_after, m_data, m_neg;

  function automatic logic [4:0] m_out();
    logic a, s, d, m;
    a = m_act && m_after == 1;
    s = m_act && m_rw && m_after == 2;
    d = m_act && !m_rw && m_after >= 2 && m_data == 8 && !m_stored;
    m = m_act && m_rw && m_after >= 3 && m_neg < 8;
    return {a, s, d, m, m_act};
  endfunction

  function automatic void m_step(input logic r_i, input logic c_i,
                                 input logic p_i, input logic n_i,
                                 input logic w_i);
    int a;
    if (r_i) begin
      m_act = 0;
    end else if (!m_act) begin
      if (!c_i) begin
        m_act = 1; m_addr = 0; m_after = 0;
        m_data = 0; m_neg = 0; m_stored = 0;
      end
    end else if (c_i) begin
      m_act = 0;
    end else if (m_addr < 8) begin
      if (p_i) begin
        m_addr++;
        if (m_addr == 8) m_after = 1;
      end
    end else begin
      a = m_after;
      if (a == 1) m_rw = w_i;
      if (!m_rw && a >= 2) begin
        if (m_data == 8) m_stored = 1;
        else if (p_i) m_data++;
      end
      if (m_rw && a >= 3 && m_neg < 8 && n_i) m_neg++;
      if (a < 100) m_after = a + 1;
    end
  endfunction

  initial begin
    reset = 1'b1; cs = 1'b1; pe = 1'b0; ne = 1'b0; rw = 1'b0;

    // Table: reset dominance, then a complete write transaction
    add(1, 0, 1, 1, 1, O_NONE);
    add(1, 0, 0, 1, 0, O_NONE);
    add(1, 0, 1, 0, 1, O_NONE);
    add(0, 0, 1, 0, 0, O_BUSY);
    for (int i = 1; i <= 8; i++)
      add(0, 0, 1, 0, 0, (i == 8) ? O_AWE : O_BUSY);
    add(0, 0, 0, 0, 0, O_BUSY);
    for (int i = 1; i <= 8; i++)
      add(0, 0, 1, i[0], 1, (i == 8) ? O_DME : O_BUSY);
    add(0, 0, 1, 1, 0, O_BUSY);
    add(0, 0, 0, 0, 0, O_BUSY);
    add(0, 1, 0, 0, 0, O_NONE);
    add(0, 1, 1, 1, 0, O_NONE);
    foreach (vecs[i])
      step(vecs[i].r, vecs[i].c, vecs[i].p, vecs[i].n, vecs[i].w,
           vecs[i].exp, "table");

    // Read transaction
    step(0, 0, 0, 0, 0, O_BUSY, "rd_start");
    for (int i = 1; i <= 8; i++)
      step(0, 0, 1, 0, 1, (i == 8) ? O_AWE : O_BUSY, "rd_addr");
    step(0, 0, 0, 0, 1, O_SRL, "rd_load");
    step(0, 0, 0, 0, 0, O_MISO, "rd_send");
    step(0, 0, 1, 0, 0, O_MISO, "rd_pos_ignored");
    for (int i = 1; i <= 8; i++)
      step(0, 0, 1, 1, 0, (i == 8) ? O_BUSY : O_MISO, "rd_neg");
    step(0, 0, 0, 1, 0, O_BUSY, "rd_done_hold");
    step(0, 1, 0, 0, 0, O_NONE, "rd_cs_release");

    // Abort at bit 5 of the address, then a full restart
    step(0, 0, 0, 0, 0, O_BUSY, "ab_start");
    for (int i = 1; i <= 5; i++)
      step(0, 0, 1, 0, 0, O_BUSY, "ab_addr");
    step(0, 1, 1, 0, 0, O_NONE, "ab_abort");
    step(0, 0, 0, 0, 0, O_BUSY, "ab_restart");
    for (int i = 1; i <= 8; i++)
      step(0, 0, 1, 0, 0, (i == 8) ? O_AWE : O_BUSY, "ab_full_addr");
    step(0, 0, 0, 0, 0, O_BUSY, "ab_write_get");

    // CS rises together with the 8th data pulse: no store
    for (int i = 1; i <= 7; i++)
      step(0, 0, 1, 0, 0, O_BUSY, "cs8_data");
    step(0, 1, 1, 0, 0, O_NONE, "cs8_abort");
    step(0, 1, 0, 0, 0, O_NONE, "cs8_idle");

    // Simultaneous pulses in WRITE_GET; negedge-only pulses ignored
    step(0, 0, 0, 0, 0, O_BUSY, "pn_start");
    for (int i = 1; i <= 8; i++)
      step(0, 0, 1, 0, 0, (i == 8) ? O_AWE : O_BUSY, "pn_addr");
    step(0, 0, 0, 0, 0, O_BUSY, "pn_write_get");
    for (int i = 1; i <= 5; i++)
      step(0, 0, 0, 1, 0, O_BUSY, "pn_neg_only");
    for (int i = 1; i <= 8; i++)
      step(0, 0, 1, 1, 0, (i == 8) ? O_DME : O_BUSY, "pn_both");
    step(0, 0, 0, 0, 0, O_BUSY, "pn_done");
    for (int i = 1; i <= 3; i++)
      step(0, 0, 1, 1, 0, O_BUSY, "pn_done_pulses");
    step(0, 1, 0, 0, 0, O_NONE, "pn_release");

    // Randomized run against the model
    m_act = 0; m_rw = 0; m_stored = 0;
    m_addr = 0; m_after = 0; m_data = 0; m_neg = 0;
    for (int i = 0; i < 4000; i++) begin
      logic r_i, c_i, p_i, n_i, w_i;
      r_i = (i == 0) || ($urandom_range(0, 599) == 0);
      c_i = ($urandom_range(0, 99) < 3);
      p_i = ($urandom_range(0, 99) < 45);
      n_i = ($urandom_range(0, 99) < 45);
      w_i = $urandom_range(0, 1) == 1;
      m_step(r_i, c_i, p_i, n_i, w_i);
      step(r_i, c_i, p_i, n_i, w_i, m_out(), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
